serial_8bit_subtractor: RTL and testbench
=========================================

SERIAL_8BIT_SUBTRACTOR -- requirements
Module: serial_8bit_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: one clock, reset synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the operands are presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH, the minuend and subtrahend (two's complement or unsigned).
REQ-007 The block SHALL have port bin, input, 1, the borrow-in.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the result is presented.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream accepts the result.
REQ-010 The block SHALL have port diff, output, WIDTH, equal to a - b - bin modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1, the borrow-out; it is 1 when a < b + bin (unsigned).
REQ-012 The block SHALL have port ovf, output, 1, the signed overflow of a - b - bin.
REQ-013 The block SHALL have port busy, output, 1, asserted while state is BUSY.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 An accept SHALL be defined as in_valid && in_ready at a rising edge; on an accept the block latches a, b and bin, clears the bit counter, and enters BUSY.
REQ-018 In BUSY, each cycle SHALL process one bit, LSB first, through one full-subtractor cell: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-019 The result bit SHALL shift into diff from the MSB side, so diff is complete after WIDTH steps.
REQ-020 After the step for bit WIDTH-1, the FSM SHALL enter DONE with these values: bout = final borrow; ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-021 out_valid SHALL rise exactly WIDTH rising edges after the accepting edge (8 for the default).
REQ-022 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.
REQ-023 diff, bout and ovf SHALL hold stable while in DONE and out_ready = 0, with no limit on stall length.
REQ-024 In DONE with out_ready = 1 at a rising edge, the FSM SHALL return to IDLE; in_ready is 1 in the following cycle, and there is no same-cycle re-accept.
REQ-025 in_valid in BUSY or DONE SHALL be ignored; changes to a, b or bin during BUSY SHALL NOT affect the result.
REQ-026 diff, bout and ovf SHALL retain the last result in IDLE and BUSY; they are valid only while out_valid = 1.

Reset
REQ-027 While rst_n = 0 at a rising edge, the block SHALL set state to IDLE, diff to 0, bout to 0, ovf to 0, the counter to 0 and the internal operand and borrow registers to 0.
REQ-028 After that reset edge, the outputs SHALL be in_ready = 1, out_valid = 0 and busy = 0.
REQ-029 A reset in BUSY or DONE SHALL abandon the operation, produce no out_valid pulse, and be followed by a clean next accept.
REQ-030 rst_n SHALL take priority over every other input in the same cycle.

Structure
REQ-031 Package sub_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-032 The 1-bit full subtractor SHALL be sub-module full_subtractor_cell (inputs a, b, bin; outputs d, bout), instantiated once and reused serially.
REQ-033 All state SHALL be in a single clocked process, with no latches and no combinational loops.

Verification
REQ-034 Basic: a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0, with out_valid exactly 8 cycles after accept.
REQ-035 Underflow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; and a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
REQ-036 Signed overflow: a=0x80, b=0x01, bin=0 -> diff=0x7F, ovf=1, bout=0; and a=0x7F, b=0xFF, bin=0 -> diff=0x80, ovf=1, bout=1.
REQ-037 Backpressure and ignore: hold out_ready=0 for 20 cycles, then check the result is unchanged and in_ready=0 throughout; change a and b mid-BUSY, then check the result uses the latched values.
REQ-038 Reset mid-operation: drop rst_n at BUSY step 4 -> next cycle in_ready=1, out_valid=0 and diff=0; then a new accept of 0xFF-0x0F -> diff=0xF0.
REQ-039 Random: 1000 random a, b and bin with random out_ready stalls, checked against a reference model of a-b-bin, with in_valid never dropped by the block.

Source files
------------

// File: rtl/serial_8bit_subtractor_pkg.sv
// sub_pkg: shared FSM state encoding and default operand width for the serial subtractor.
package sub_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_8bit_subtractor_if.sv
// serial_8bit_subtractor_if: operand/result handshake bundle between a requester and the subtractor.
interface serial_8bit_subtractor_if
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, busy
    );
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, busy
    );
endinterface

// File: rtl/serial_8bit_subtractor_cell.sv
// full_subtractor_cell: one-bit full subtractor, d = a - b - bin with borrow-out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_8bit_subtractor.sv
// serial_8bit_subtractor: bit-serial a - b - bin, one bit per cycle LSB first, valid/ready on both sides.
module serial_8bit_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    serial_8bit_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
    logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d;
    logic             cell_d, cell_bout, last;
    full_subtractor_cell u_cell (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .bin  (br_q),
        .d    (cell_d),
        .bout (cell_bout)
    );
    assign last          = cnt_q == CW'(WIDTH - 1);
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q == BUSY;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = BUSY;
                a_d     = bus.a;
                b_d     = bus.b;
                br_d    = bus.bin;
                cnt_d   = '0;
            end
            BUSY: begin
                acc_d = {cell_d, acc_q[WIDTH-1:1]};
                br_d  = cell_bout;
                cnt_d = last ? cnt_q : cnt_q + 1'b1;
                // Published result only changes on completion so diff keeps the last answer during BUSY
                if (last) begin
                    state_d = DONE;
                    diff_d  = acc_d;
                    bout_d  = cell_bout;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_d != a_q[WIDTH-1]);
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            acc_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_8bit_subtractor.sv
// tb_serial_8bit_subtractor: scoreboard bench for the serial subtractor (directed vectors, stalls, reset, random).
module tb_serial_8bit_subtractor;
    localparam int W  = 8;
    localparam int RW = 2 * W + 1;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [W+1:0] sb_q[$];
    always #5 clk = ~clk;
    serial_8bit_subtractor_if #(.WIDTH(W)) bus ();
    serial_8bit_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W:0] r;
        r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        return {r[W-1:0], r[W], (a[W-1] != b[W-1]) && (r[W-1] != a[W-1])};
    endfunction
    // Called just after a falling edge with the block idle; returns just after a falling edge, idle again.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W+1:0] exp, input int stall, input bit hold);
        int n;
        logic [W+1:0] e;
        logic [W-1:0] d0;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_op: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        if (hold) {bus.a, bus.b, bus.bin} = RW'($urandom);
        else begin
            bus.in_valid = 1'b0;
            bus.a = ~a;
            bus.b = ~b;
            bus.bin = ~bin;
        end
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_state: busy=%b in_ready=%b out_valid=%b required 1 0 0", bus.busy, bus.in_ready, bus.out_valid);
        end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (hold) {bus.a, bus.b, bus.bin} = RW'($urandom);
        end
        checks++;
        if (n != W) begin
            errors++;
            $display("FAIL latency: out_valid after %0d edges required %0d", n, W);
        end
        d0 = bus.diff;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== d0) begin
                errors++;
                $display("FAIL stall: out_valid=%b in_ready=%b diff=%h required 1 0 %h", bus.out_valid, bus.in_ready, bus.diff, d0);
            end
        end
        e = sb_q.pop_front();
        checks++;
        if ({bus.diff, bus.bout, bus.ovf} !== e) begin
            errors++;
            $display("FAIL result a=%h b=%h bin=%b: diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
                     a, b, bin, bus.diff, bus.bout, bus.ovf, e[W+1:2], e[1], e[0]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL release: in_ready=%b out_valid=%b busy=%b required 1 0 0", bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.bin = 1'b1;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.diff !== '0 || bus.bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b diff=%h bout=%b ovf=%b required 1 0 0 00 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.diff, bus.bout, bus.ovf);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
    endtask
    task automatic test_basic();
        do_op(8'h05, 8'h03, 1'b0, {8'h02, 1'b0, 1'b0}, 0, 1'b0);
    endtask
    task automatic test_underflow();
        do_op(8'h00, 8'h01, 1'b0, {8'hFF, 1'b1, 1'b0}, 0, 1'b0);
        do_op(8'h00, 8'h00, 1'b1, {8'hFF, 1'b1, 1'b0}, 1, 1'b0);
    endtask
    task automatic test_overflow();
        do_op(8'h80, 8'h01, 1'b0, {8'h7F, 1'b0, 1'b1}, 0, 1'b0);
        do_op(8'h7F, 8'hFF, 1'b0, {8'h80, 1'b1, 1'b1}, 2, 1'b0);
    endtask
    task automatic test_backpressure();
        do_op(8'hC3, 8'h5A, 1'b1, {8'h68, 1'b0, 1'b1}, 20, 1'b0);
        do_op(8'h10, 8'h20, 1'b0, {8'hF0, 1'b1, 1'b0}, 5, 1'b1);
    endtask
    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.a = 8'h33;
        bus.b = 8'h11;
        bus.bin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.diff !== '0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b diff=%h required 1 0 0 00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.diff);
        end
        rst_n = 1'b1;
        do_op(8'hFF, 8'h0F, 1'b0, {8'hF0, 1'b0, 1'b0}, 0, 1'b0);
    endtask
    task automatic test_random();
        logic [W-1:0] a, b;
        logic bin;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom);
            do_op(a, b, bin, model(a, b, bin), int'($urandom_range(0, 3)), 1'($urandom));
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
